// File: rtl/cell_bist_pkg.sv
// Shared types and helpers for the standard-cell BIST sequencer.
//   state_t  : sequencer states
//   timer_w  : width of the settle down-counter, clog2(settle) with a floor of 1
package cell_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // The counter is loaded with settle-1, so clog2(settle) bits always hold it.
    function automatic int timer_w(input int settle);
        return (settle > 2) ? $clog2(settle) : 1;
    endfunction

endpackage

// File: rtl/cell_bist_timer.sv
// Loadable down-counter used for the per-vector settle wait.
//   ck       : clock, rising edge
//   rst      : asynchronous active-high reset
//   load     : load load_val this cycle (wins over counting)
//   load_val : value to load
//   zero     : count has reached zero
// The counter stops at zero until reloaded.
module cell_bist_timer #(
    parameter int W = 1
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/cell_bist_ctrl.sv
// BIST sequencer for one combinational cell.
// Walks every input vector, holds each for SETTLE cycles, then compares the
// cell output against TRUTH and accumulates the result.
//   ck, rst    : clock, asynchronous active-high reset
//   start      : begin a run (only looked at in IDLE)
//   abort      : cancel a run in progress
//   dut_i      : cell input vector (value == vector index)
//   dut_nq     : cell output
//   busy       : run in progress
//   done       : one-cycle pulse on run completion
//   pass       : result of last completed run
//   err_cnt    : mismatch count
//   fail_vec   : first mismatching vector, fail_valid qualifies it
module cell_bist_ctrl
    import cell_bist_pkg::*;
#(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 2,
    parameter logic [2**N_IN-1:0] TRUTH  = 4'b0001
) (
    input  logic            ck,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] dut_i,
    input  logic            dut_nq,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] fail_vec,
    output logic            fail_valid
);

    localparam int              TW       = timer_w(SETTLE);
    localparam logic [TW-1:0]   LOAD_VAL = TW'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_t          r_state, w_next;
    logic [N_IN-1:0] r_vec;
    logic [N_IN:0]   r_err_cnt;
    logic [N_IN-1:0] r_fail_vec;
    logic            r_fail_valid;
    logic            r_pass;
    logic            r_busy;
    logic            r_done;

    logic w_accept;    // run accepted in IDLE
    logic w_check;     // compare this vector
    logic w_finish;    // leaving DONE
    logic w_abort;     // run cancelled
    logic w_load;      // reload settle timer
    logic w_zero;
    logic w_mismatch;

    cell_bist_timer #(.W(TW)) u_timer (
        .ck       (ck),
        .rst      (rst),
        .load     (w_load),
        .load_val (LOAD_VAL),
        .zero     (w_zero)
    );

    assign w_mismatch = (dut_nq != TRUTH[r_vec]);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_check  = 1'b0;
        w_finish = 1'b0;
        w_abort  = 1'b0;
        w_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_next   = ST_SETTLE;
                    w_accept = 1'b1;
                    w_load   = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_next  = ST_IDLE;
                    w_abort = 1'b1;
                end else if (w_zero) begin
                    w_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // An abort here drops the compare so partial results stay as they were.
                if (abort) begin
                    w_next  = ST_IDLE;
                    w_abort = 1'b1;
                end else begin
                    w_check = 1'b1;
                    if (r_vec == LAST_VEC) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next = ST_SETTLE;
                        w_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_next   = ST_IDLE;
                w_finish = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_vec        <= '0;
            r_err_cnt    <= '0;
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
            r_pass       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_busy <= (w_next != ST_IDLE);
            r_done <= w_finish;
            if (w_accept) begin
                r_vec        <= '0;
                r_err_cnt    <= '0;
                r_fail_vec   <= '0;
                r_fail_valid <= 1'b0;
                r_pass       <= 1'b0;
            end
            if (w_check) begin
                if (w_mismatch) begin
                    r_err_cnt <= r_err_cnt + (N_IN+1)'(1);
                    if (!r_fail_valid) begin
                        r_fail_vec   <= r_vec;
                        r_fail_valid <= 1'b1;
                    end
                end
                // The last vector stays on the cell through DONE.
                if (r_vec != LAST_VEC) r_vec <= r_vec + N_IN'(1);
            end
            if (w_finish) begin
                r_pass <= (r_err_cnt == '0);
                r_vec  <= '0;
            end
            if (w_abort) begin
                r_pass <= 1'b0;
                r_vec  <= '0;
            end
        end
    end

    assign dut_i      = r_vec;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_cnt    = r_err_cnt;
    assign fail_vec   = r_fail_vec;
    assign fail_valid = r_fail_valid;

endmodule
